// File: rtl/irq_controller_if.sv
// CPU data-bus port of the interrupt controller.
// The CPU side is the master; the controller is the slave.
interface irq_controller_if;
  logic [15:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic        hit;

  modport master (
    output address, data, wren,
    input  q, hit
  );

  modport slave (
    input  address, data, wren,
    output q, hit
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, maskable, lowest-index-first interrupt controller
// with a four-word register window on the CPU data bus.
module irq_controller #(
  parameter int unsigned N_LINES   = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LINES-1:0] irq_lines,
  irq_controller_if.slave    bus,
  input  logic               ack,
  output logic               IRQ,
  output logic [7:0]         IRQn
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [N_LINES-1:0] ONE = N_LINES'(1);

  logic [N_LINES-1:0] sync1;
  logic [N_LINES-1:0] sync2;
  logic [N_LINES-1:0] prev;
  logic [N_LINES-1:0] edges;
  logic [N_LINES-1:0] pending;
  logic [N_LINES-1:0] mask;
  logic [N_LINES-1:0] req;
  logic [N_LINES-1:0] vec_oh;
  logic [N_LINES-1:0] w1c;
  logic [N_LINES-1:0] ack_clr;
  logic [2:0]         arm;
  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [7:0]         vec;
  logic [7:0]         vec_n;
  logic [7:0]         winner;
  logic [15:0]        off;
  logic               sel;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_eoi;
  logic               take_ack;
  logic [31:0]        rdata;
  logic               unused_data;

  assign off      = bus.address - BASE_ADDR;
  assign sel      = off[15:2] == 14'd0;
  assign wr_pend  = bus.wren && sel && off[1:0] == 2'd0;
  assign wr_mask  = bus.wren && sel && off[1:0] == 2'd1;
  assign wr_eoi   = bus.wren && sel && off[1:0] == 2'd3;
  assign unused_data = ^bus.data;

  // Edges stay blocked until prev holds a real sample, so a line
  // already high when reset is released is not seen as a rise.
  assign edges    = arm[2] ? (sync2 & ~prev) : '0;
  assign req      = pending & mask;
  assign vec_oh   = ONE << vec;
  assign take_ack = (state == ASSERT) && ack;
  assign w1c      = wr_pend ? bus.data[N_LINES-1:0] : '0;
  assign ack_clr  = take_ack ? vec_oh : '0;
  assign IRQn     = vec;

  always_comb begin
    winner = 8'd0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (req[i]) winner = 8'(i);
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    unique case (state)
      IDLE: begin
        if (req != '0) begin
          state_n = ASSERT;
          vec_n   = winner;
        end
      end
      ASSERT: begin
        if (take_ack)
          state_n = SERVICE;
        else if ((req & vec_oh) == '0)
          state_n = IDLE;
      end
      SERVICE: begin
        if (wr_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (off[1:0])
      2'd0:    rdata = 32'(pending);
      2'd1:    rdata = 32'(mask);
      2'd2:    rdata = {22'd0, state, vec};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      arm     <= '0;
      pending <= '0;
      mask    <= '0;
      state   <= IDLE;
      vec     <= '0;
      IRQ     <= 1'b0;
      bus.q   <= '0;
      bus.hit <= 1'b0;
    end else begin
      sync1   <= irq_lines;
      sync2   <= sync1;
      prev    <= sync2;
      arm     <= {arm[1:0], 1'b1};
      // a fresh edge beats both W1C and ack on the same bit
      pending <= (pending & ~w1c & ~ack_clr) | edges;
      if (wr_mask) mask <= bus.data[N_LINES-1:0];
      state   <= state_n;
      vec     <= vec_n;
      IRQ     <= state_n == ASSERT;
      bus.q   <= sel ? rdata : '0;
      bus.hit <= sel;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level reference
// model and per-cycle output comparison.
module tb_irq_controller;
  localparam int          N      = 8;
  localparam logic [15:0] BASE   = 16'hFF00;
  localparam logic [15:0] A_PEND = BASE;
  localparam logic [15:0] A_MASK = BASE + 16'd1;
  localparam logic [15:0] A_VEC  = BASE + 16'd2;
  localparam logic [15:0] A_EOI  = BASE + 16'd3;

  logic         clk;
  logic         reset;
  logic [N-1:0] irq_lines;
  logic         ack;
  logic         IRQ;
  logic [7:0]   IRQn;
  int           total;
  int           bad;

  irq_controller_if bus();

  irq_controller #(.N_LINES(N), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .irq_lines(irq_lines),
    .bus(bus),
    .ack(ack),
    .IRQ(IRQ),
    .IRQn(IRQn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: sample history, plain ints for registers
  int m_hist [3];
  int m_since;
  int m_pend;
  int m_mask;
  int m_state;
  int m_vec;
  int m_q;
  bit m_irq;
  bit m_hit;

  function automatic int lowest(int r);
    return $clog2(r & -r);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist  = '{0, 0, 0};
      m_since = 0;
      m_pend  = 0;
      m_mask  = 0;
      m_state = 0;
      m_vec   = 0;
      m_q     = 0;
      m_irq   = 0;
      m_hit   = 0;
    end else begin
      int off;
      int edges;
      int req;
      int w1c;
      int ackc;
      int full;
      full = (1 << N) - 1;
      off  = int'(bus.address) - int'(BASE);
      m_hit = off >= 0 && off < 4;
      case (off)
        0:       m_q = m_pend;
        1:       m_q = m_mask;
        2:       m_q = m_state * 256 + m_vec;
        default: m_q = 0;
      endcase
      edges = (m_since >= 3) ? (m_hist[1] & ~m_hist[2]) : 0;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(irq_lines);
      if (m_since < 3) m_since++;
      req  = m_pend & m_mask;
      w1c  = (bus.wren && off == 0) ? (int'(bus.data) & full) : 0;
      ackc = 0;
      case (m_state)
        0: if (req != 0) begin
             m_vec   = lowest(req);
             m_state = 1;
           end
        1: if (ack) begin
             ackc    = 1 << m_vec;
             m_state = 2;
           end else if (((req >> m_vec) & 1) == 0) begin
             m_state = 0;
           end
        default: if (bus.wren && off == 3) m_state = 0;
      endcase
      if (bus.wren && off == 1) m_mask = int'(bus.data) & full;
      m_pend = (m_pend & ~w1c & ~ackc) | edges;
      m_irq  = m_state == 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (IRQ !== m_irq || IRQn !== 8'(m_vec) ||
          bus.q !== 32'(m_q) || bus.hit !== m_hit) begin
        bad++;
        $display("FAIL cycle@%0t: IRQ=%b/%b IRQn=%0d/%0d q=%h/%h hit=%b/%b",
                 $time, IRQ, m_irq, IRQn, m_vec, bus.q, m_q, bus.hit, m_hit);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [15:0] a, logic [31:0] d);
    bus.address = a;
    bus.data    = d;
    bus.wren    = 1'b1;
    step(1);
    bus.wren    = 1'b0;
    bus.address = 16'h0;
    bus.data    = '0;
  endtask

  task automatic rd(string name, logic [15:0] a, logic [31:0] exp,
                    logic exp_hit = 1'b1);
    bus.address = a;
    step(1);
    chk(name, bus.q, exp);
    chk({name, "_hit"}, 32'(bus.hit), 32'(exp_hit));
    bus.address = 16'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    irq_lines   = '0;
    ack         = 1'b0;
    bus.address = 16'h0;
    bus.data    = '0;
    bus.wren    = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_irq", 32'(IRQ), 0);
    rd("rst_mask", A_MASK, 0);

    // basic flow on line 3
    wr(A_MASK, 32'h08);
    irq_lines[3] = 1'b1;
    step(3);
    irq_lines[3] = 1'b0;
    chk("irq_k2", 32'(IRQ), 0);
    step(1);
    chk("irq_k3", 32'(IRQ), 1);
    chk("vec_k3", 32'(IRQn), 3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("irq_ack", 32'(IRQ), 0);
    rd("pend_ack", A_PEND, 0);
    rd("vector_svc", A_VEC, 32'h0000_0203);
    wr(A_EOI, 32'hDEAD_BEEF);
    rd("vector_eoi", A_VEC, 32'h0000_0003);

    // priority between lines 5 and 2
    wr(A_MASK, 32'hFF);
    irq_lines = 8'h24;
    step(3);
    irq_lines = '0;
    step(1);
    chk("prio_irq", 32'(IRQ), 1);
    chk("prio_vec", 32'(IRQn), 2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    wr(A_EOI, 32'h0);
    chk("prio_eoi_irq", 32'(IRQ), 0);
    step(1);
    chk("prio2_irq", 32'(IRQ), 1);
    chk("prio2_vec", 32'(IRQn), 5);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    wr(A_EOI, 32'h0);

    // masking and withdraw on line 1
    wr(A_MASK, 32'h0);
    irq_lines[1] = 1'b1;
    step(3);
    irq_lines[1] = 1'b0;
    step(3);
    rd("pend_masked", A_PEND, 32'h2);
    chk("irq_masked", 32'(IRQ), 0);
    wr(A_MASK, 32'h02);
    chk("irq_mask_wr", 32'(IRQ), 0);
    step(1);
    chk("irq_unmask", 32'(IRQ), 1);
    chk("vec_unmask", 32'(IRQn), 1);
    wr(A_MASK, 32'h0);
    chk("irq_wd_hold", 32'(IRQ), 1);
    step(1);
    chk("irq_wd", 32'(IRQ), 0);
    rd("vector_wd", A_VEC, 32'h0000_0001);
    wr(A_PEND, 32'h2);
    rd("pend_w1c", A_PEND, 0);

    // edge and W1C on line 0 in the same cycle
    irq_lines[0] = 1'b1;
    step(2);
    wr(A_PEND, 32'h1);
    irq_lines[0] = 1'b0;
    rd("pend_w1c_col", A_PEND, 32'h1);
    wr(A_PEND, 32'h1);
    rd("pend_w1c_clr", A_PEND, 0);

    // bus decode
    rd("q_out4", BASE + 16'd4, 0, 1'b0);
    rd("q_zero", 16'h0000, 0, 1'b0);
    wr(A_MASK, 32'h5A);
    rd("mask_rd", A_MASK, 32'h5A);
    wr(BASE + 16'd4, 32'hFF);
    wr(16'hFEFF, 32'hFF);
    wr(16'h0000, 32'hFF);
    rd("mask_keep", A_MASK, 32'h5A);
    rd("pend_keep", A_PEND, 0);
    wr(A_MASK, 32'hFFFF_FF0F);
    rd("mask_upper", A_MASK, 32'h0F);
    rd("eoi_rd", A_EOI, 0);

    // reset in the middle of an active request
    wr(A_MASK, 32'h10);
    irq_lines[4] = 1'b1;
    step(3);
    irq_lines[4] = 1'b0;
    step(1);
    chk("pre_rst_irq", 32'(IRQ), 1);
    bus.address = A_MASK;
    step(1);
    chk("pre_rst_hit", 32'(bus.hit), 1);
    irq_lines[6] = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_irq_now", 32'(IRQ), 0);
    chk("rst_vec_now", 32'(IRQn), 0);
    chk("rst_q_now", bus.q, 0);
    chk("rst_hit_now", 32'(bus.hit), 0);
    step(2);
    bus.address = 16'h0;
    reset = 1'b0;
    rd("rst_pend", A_PEND, 0);
    rd("rst_mask2", A_MASK, 0);
    wr(A_MASK, 32'hFF);
    step(4);
    chk("hi_at_release_irq", 32'(IRQ), 0);
    rd("hi_at_release_pend", A_PEND, 0);
    irq_lines = '0;
    step(3);
    irq_lines[6] = 1'b1;
    step(3);
    irq_lines = '0;
    step(1);
    chk("line6_irq", 32'(IRQ), 1);
    chk("line6_vec", 32'(IRQn), 6);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that sits beside the RAM on the CPU data bus and drives the CPU's `IRQ`/`IRQn` inputs. It synchronises up to 8 external interrupt lines, latches rising edges into a pending register, applies a software mask, and presents the highest-priority request to the CPU. A request is held until acknowledged and closed by an end-of-interrupt write. Its registers are reached with ordinary CPU LOAD/STORE cycles.

## Interface
- `N_LINES`, 8: number of interrupt lines, legal range 1..8.
- `BASE_ADDR`, 16'hFF00: word address of register 0. Registers occupy `BASE_ADDR`..`BASE_ADDR+3`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `irq_lines` in N_LINES: asynchronous external requests, rising-edge triggered.
- `address` in 16: CPU bus word address.
- `data` in 32: CPU bus write data.
- `wren` in 1: CPU bus write enable.
- `q` out 32: registered read data. It is 0 when the previous address was unselected.
- `hit` out 1: registered. High when `q` carries controller data; used by the external read mux.
- `ack` in 1: one-cycle acknowledge from the CPU interrupt entry logic.
- `IRQ` out 1: interrupt request to the CPU.
- `IRQn` out 8: vector (line index) of the current request.

## Operation
- Synchroniser and pending register:
  - Each line passes through a 2-flop synchroniser, then a rising-edge detector that compares against the previous synchronised value.
  - A detected edge sets `pending[i]`.
- Register map (offset = `address - BASE_ADDR`; writes take effect when `wren` is high and the address is in range):
  - 0 PENDING: read gives `pending` zero-extended. A write with 1 clears the corresponding bit (W1C).
  - 1 MASK: read/write, bit i = 1 enables line i. Reset value 0 (all masked).
  - 2 VECTOR: read only. Bits 9:8 hold the state code (IDLE=0, ASSERT=1, SERVICE=2); bits 7:0 hold the current vector.
  - 3 EOI: write (any data) ends service. Reads return 0.
  - Bits at and above `N_LINES` in PENDING and MASK are read 0 and ignore writes.
- Priority: `req = pending & mask`. The lowest set index wins.
- State machine:
  - IDLE: when `req != 0`, latch the winner into `vec` and go to ASSERT.
  - ASSERT: `IRQ` = 1, `IRQn` = `vec`.
    - On `ack`: clear `pending[vec]` and go to SERVICE.
    - If `req[vec]` drops before `ack` (masked or W1C-cleared): withdraw and return to IDLE. No ack is needed.
  - SERVICE: `IRQ` = 0, and `IRQn` keeps `vec`. New edges still set pending bits, but nothing is presented (no nesting). An EOI write returns to IDLE.
- Ignored inputs: `ack` outside ASSERT, and EOI outside SERVICE.
- Collisions:
  - An edge and a W1C on the same bit in the same cycle leave the bit set.
  - `ack` and an edge on `vec` in the same cycle leave the bit set, so the line is re-requested after EOI.
  - A MASK write takes effect for arbitration on the cycle after the write.
- Reset values (async): synchronisers 0, `pending` 0, `mask` 0, state IDLE, `vec` 0, `IRQ` 0, `IRQn` 0, `q` 0, `hit` 0. Reset mid-request drops `IRQ` immediately and loses all pending events.
- A line that is already high when reset is released produces no edge.

## Timing
- Read latency is one cycle. `q`/`hit` are registered from the `address` present at edge k and valid after edge k, which matches the CPU sampling `q` in the state after it issues a LOAD address.
- A write takes effect at the edge where `wren` is sampled high.
- Interrupt latency from the external line:
  - Line high before edge k: synchronised after k+1, `pending` set at k+2.
  - IDLE→ASSERT at k+3, so `IRQ`/`IRQn` are high/valid after edge k+3 (registered outputs).
- `ack` sampled at edge m: `IRQ` low and pending bit clear after m. The state is SERVICE.
- EOI sampled at edge e: IDLE after e. If `req != 0`, `IRQ` is high again after e+1.
- Withdraw: the cycle after `req[vec]` falls, `IRQ` is low.
- Minimum line pulse width is 2 clocks high and 2 clocks low between edges. Shorter pulses may be missed.

## Test plan
- Reset: assert `reset` mid-ASSERT → `IRQ`, `IRQn`, `q`, `hit` = 0 immediately, and reads of PENDING and MASK return 0 after release.
- Basic flow:
  - Stimulus: MASK=8'h08, then pulse line 3 at edge k.
  - Response: `IRQ`=1 and `IRQn`=3 after k+3.
  - `ack` → `IRQ`=0 and PENDING=0; VECTOR read = 32'h0000_0203.
  - EOI → VECTOR = 32'h0000_0003.
- Priority: MASK=8'hFF, pulse lines 5 and 2 together → `IRQn`=2. After ack+EOI, `IRQn`=5 one cycle after EOI.
- Masking and withdraw:
  - Edge on line 1 with MASK=0 → PENDING=32'h2 and `IRQ` stays 0.
  - Setting MASK=8'h02 → `IRQ`=1.
  - Then writing MASK=0 before ack → `IRQ`=0 one cycle later, and state is IDLE.
- W1C collision: the cycle a line 0 edge is detected, write PENDING=1 → PENDING reads 32'h1.
- Bus decode: read `BASE_ADDR+4` and 16'h0000 → `hit`=0 and `q`=0. Read MASK → `hit`=1 one cycle after the address. Writes outside the range leave all registers unchanged.
